// File: rtl/pid_mc_pkg.sv
// Shared types and arithmetic helpers for the multi-channel PID controller.
// Saturation helpers work on a 64-bit signed carrier; callers truncate to their width.
package pid_mc_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 13;
    localparam int DEF_SHW = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ERR  = 3'd1,
        S_INT  = 3'd2,
        S_MUL  = 3'd3,
        S_SHF  = 3'd4,
        S_SUM  = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    // Saturate x into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Symmetric magnitude clamp to [-lim, lim].
    function automatic logic signed [63:0] clamp_lim(input logic signed [63:0] x,
                                                     input logic signed [63:0] lim);
        if (x > lim)  return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

endpackage

// File: rtl/pid_mc_if.sv
// Sample handshake and result bus between the feedback sampler, the PID core and the PWM side.
interface pid_mc_if #(
    parameter int NCH = 4,
    parameter int W   = 13
);
    localparam int CHW = $clog2(NCH);

    logic                  in_valid;
    logic                  in_ready;
    logic [CHW-1:0]        in_chan;
    logic signed [W-1:0]   pos_d;
    logic signed [W-1:0]   pos;
    logic signed [W-1:0]   vel_d;
    logic signed [W-1:0]   vel;

    logic                  out_valid;
    logic [CHW-1:0]        out_chan;
    logic signed [W-1:0]   pwm;
    logic                  dir;
    logic signed [W-1:0]   err;
    logic signed [W-1:0]   int_err;

    modport master (
        output in_valid, in_chan, pos_d, pos, vel_d, vel,
        input  in_ready, out_valid, out_chan, pwm, dir, err, int_err
    );

    modport slave (
        input  in_valid, in_chan, pos_d, pos, vel_d, vel,
        output in_ready, out_valid, out_chan, pwm, dir, err, int_err
    );
endinterface

// File: rtl/pid_shift_sat.sv
// Floor (arithmetic) right shift of a double-width product, saturated back to W bits.
module pid_shift_sat
    import pid_mc_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int SHW = DEF_SHW
) (
    input  logic signed [2*W-1:0] din,
    input  logic [SHW-1:0]        sh,
    output logic signed [W-1:0]   dout
);
    logic signed [2*W-1:0] shifted;

    always_comb begin
        shifted = din >>> sh;
        dout    = W'(sat_w(64'(shifted), W));
    end
endmodule

// File: rtl/pid_mc.sv
// Time-multiplexed PID core: one sample walks ERR->INT->MUL->SHF->SUM->OUT,
// with per-channel error history and integrator held in flops.
module pid_mc
    import pid_mc_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int W   = DEF_W,
    parameter int SHW = DEF_SHW
) (
    input  logic                    clk,
    input  logic                    reset,
    pid_mc_if.slave                 bus,
    input  logic [NCH-1:0]          mode,
    input  logic [NCH*W-1:0]        kp_n,
    input  logic [NCH*W-1:0]        ki_n,
    input  logic [NCH*W-1:0]        kd_n,
    input  logic [NCH*SHW-1:0]      kp_sh,
    input  logic [NCH*SHW-1:0]      ki_sh,
    input  logic [NCH*SHW-1:0]      kd_sh,
    input  logic signed [W-1:0]     int_lim,
    input  logic signed [W-1:0]     pwm_max,
    input  logic                    clr_valid,
    input  logic [$clog2(NCH)-1:0]  clr_chan
);
    localparam int CHW = $clog2(NCH);

    state_t                 state_q, state_d;
    logic [CHW-1:0]         chan_q, chan_d;
    logic                   chan_ok_q, chan_ok_d;
    logic                   kill_q, kill_d;
    logic signed [W-1:0]    a_q, a_d, b_q, b_d;
    logic signed [W-1:0]    int_lim_q, int_lim_d, pwm_max_q, pwm_max_d;
    logic signed [W-1:0]    gain_q [3], gain_d [3];
    logic [SHW-1:0]         shamt_q [3], shamt_d [3];
    logic signed [W-1:0]    e_q, e_d, inew_q, inew_d, de_q, de_d;
    logic signed [2*W-1:0]  prod_q [3], prod_d [3];
    logic signed [W-1:0]    term_q [3], term_d [3];
    logic signed [W-1:0]    term_w [3];
    logic                   out_valid_q, out_valid_d, dir_q, dir_d;
    logic [CHW-1:0]         out_chan_q, out_chan_d;
    logic signed [W-1:0]    pwm_q, pwm_d, err_q, err_d, int_err_q, int_err_d;

    logic [NCH*W-1:0]       int_mem_flat, err_prev_flat;
    logic signed [W-1:0]    mem_int, mem_prev;
    logic signed [W-1:0]    sel_a, sel_b, sel_kp, sel_ki, sel_kd;
    logic [SHW-1:0]         sel_psh, sel_ish, sel_dsh;
    logic                   clr_hit, wb_en;
    logic signed [W+1:0]    sum_w;

    // Per-channel selection of the offered sample and of the in-flight channel's state.
    always_comb begin
        sel_a = '0; sel_b = '0; sel_kp = '0; sel_ki = '0; sel_kd = '0;
        sel_psh = '0; sel_ish = '0; sel_dsh = '0;
        mem_int = '0; mem_prev = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.in_chan == CHW'(c)) begin
                sel_a   = mode[c] ? bus.vel_d : bus.pos_d;
                sel_b   = mode[c] ? bus.vel   : bus.pos;
                sel_kp  = kp_n[c*W +: W];
                sel_ki  = ki_n[c*W +: W];
                sel_kd  = kd_n[c*W +: W];
                sel_psh = kp_sh[c*SHW +: SHW];
                sel_ish = ki_sh[c*SHW +: SHW];
                sel_dsh = kd_sh[c*SHW +: SHW];
            end
            if (chan_q == CHW'(c)) begin
                mem_int  = int_mem_flat[c*W +: W];
                mem_prev = err_prev_flat[c*W +: W];
            end
        end
    end

    assign clr_hit = clr_valid && (clr_chan == chan_q);
    assign wb_en   = (state_q == S_SUM) && chan_ok_q && !kill_q && !clr_hit;

    for (genvar gi = 0; gi < 3; gi++) begin : g_term
        pid_shift_sat #(.W(W), .SHW(SHW)) u_shift_sat (
            .din  (prod_q[gi]),
            .sh   (shamt_q[gi]),
            .dout (term_w[gi])
        );
    end

    always_comb begin
        state_d   = state_q;   chan_d    = chan_q;    chan_ok_d = chan_ok_q;
        kill_d    = kill_q;    a_d       = a_q;       b_d       = b_q;
        int_lim_d = int_lim_q; pwm_max_d = pwm_max_q;
        e_d       = e_q;       inew_d    = inew_q;    de_d      = de_q;
        out_valid_d = out_valid_q; out_chan_d = out_chan_q; dir_d = dir_q;
        pwm_d     = pwm_q;     err_d     = err_q;     int_err_d = int_err_q;
        for (int k = 0; k < 3; k++) begin
            gain_d[k]  = gain_q[k];
            shamt_d[k] = shamt_q[k];
            prod_d[k]  = prod_q[k];
            term_d[k]  = term_q[k];
        end
        sum_w = (W+2)'(term_q[0]) + (W+2)'(term_q[1]) + (W+2)'(term_q[2]);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d    = S_ERR;
                    chan_d     = bus.in_chan;
                    chan_ok_d  = ({1'b0, bus.in_chan} < (CHW+1)'(NCH));
                    kill_d     = clr_valid && (clr_chan == bus.in_chan);
                    a_d        = sel_a;
                    b_d        = sel_b;
                    int_lim_d  = int_lim;
                    pwm_max_d  = pwm_max;
                    gain_d[0]  = sel_kp;  gain_d[1]  = sel_ki;  gain_d[2]  = sel_kd;
                    shamt_d[0] = sel_psh; shamt_d[1] = sel_ish; shamt_d[2] = sel_dsh;
                end
            end
            S_ERR: begin
                state_d = S_INT;
                kill_d  = kill_q || clr_hit;
                e_d     = W'(sat_w(64'(a_q) - 64'(b_q), W));
            end
            S_INT: begin
                state_d = S_MUL;
                kill_d  = kill_q || clr_hit;
                inew_d  = W'(clamp_lim(sat_w(64'(mem_int) + 64'(e_q), W), 64'(int_lim_q)));
                de_d    = W'(sat_w(64'(e_q) - 64'(mem_prev), W));
            end
            S_MUL: begin
                state_d   = S_SHF;
                kill_d    = kill_q || clr_hit;
                prod_d[0] = (2*W)'(gain_q[0]) * (2*W)'(e_q);
                prod_d[1] = (2*W)'(gain_q[1]) * (2*W)'(inew_q);
                prod_d[2] = (2*W)'(gain_q[2]) * (2*W)'(de_q);
            end
            S_SHF: begin
                state_d = S_SUM;
                kill_d  = kill_q || clr_hit;
                for (int k = 0; k < 3; k++) term_d[k] = term_w[k];
            end
            S_SUM: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_chan_d  = chan_q;
                if (chan_ok_q) begin
                    pwm_d     = W'(clamp_lim(sat_w(64'(sum_w), W + 2), 64'(pwm_max_q)));
                    err_d     = e_q;
                    int_err_d = inew_q;
                end else begin
                    pwm_d     = '0;
                    err_d     = '0;
                    int_err_d = '0;
                end
                dir_d = !pwm_d[W-1];
            end
            S_OUT: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE; chan_q  <= '0; chan_ok_q <= 1'b0; kill_q <= 1'b0;
            a_q       <= '0;     b_q     <= '0; int_lim_q <= '0;   pwm_max_q <= '0;
            e_q       <= '0;     inew_q  <= '0; de_q      <= '0;
            out_valid_q <= 1'b0; out_chan_q <= '0; dir_q <= 1'b1;
            pwm_q     <= '0;     err_q   <= '0; int_err_q <= '0;
            for (int k = 0; k < 3; k++) begin
                gain_q[k] <= '0; shamt_q[k] <= '0; prod_q[k] <= '0; term_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;   chan_q  <= chan_d;  chan_ok_q <= chan_ok_d; kill_q <= kill_d;
            a_q       <= a_d;       b_q     <= b_d;     int_lim_q <= int_lim_d; pwm_max_q <= pwm_max_d;
            e_q       <= e_d;       inew_q  <= inew_d;  de_q      <= de_d;
            out_valid_q <= out_valid_d; out_chan_q <= out_chan_d; dir_q <= dir_d;
            pwm_q     <= pwm_d;     err_q   <= err_d;   int_err_q <= int_err_d;
            for (int k = 0; k < 3; k++) begin
                gain_q[k] <= gain_d[k]; shamt_q[k] <= shamt_d[k];
                prod_q[k] <= prod_d[k]; term_q[k]  <= term_d[k];
            end
        end
    end

    // Channel history; a clear on the same edge overrides the SUM writeback.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_mem
        logic signed [W-1:0] int_mem_q, int_mem_d, err_prev_q, err_prev_d;

        always_comb begin
            int_mem_d  = int_mem_q;
            err_prev_d = err_prev_q;
            if (wb_en && (chan_q == CHW'(gi))) begin
                int_mem_d  = inew_q;
                err_prev_d = e_q;
            end
            if (clr_valid && (clr_chan == CHW'(gi))) begin
                int_mem_d  = '0;
                err_prev_d = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                int_mem_q  <= '0;
                err_prev_q <= '0;
            end else begin
                int_mem_q  <= int_mem_d;
                err_prev_q <= err_prev_d;
            end
        end

        assign int_mem_flat[gi*W +: W]  = int_mem_q;
        assign err_prev_flat[gi*W +: W] = err_prev_q;
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.pwm       = pwm_q;
    assign bus.dir       = dir_q;
    assign bus.err       = err_q;
    assign bus.int_err   = int_err_q;

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc: hand-computed vectors per feature, one line per sample.
module tb_pid_mc;
    localparam int NCH = 4;
    localparam int W   = 13;
    localparam int SHW = 4;
    localparam int CHW = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NCH-1:0]       mode = '0;
    logic [NCH*W-1:0]     kp_n = '0, ki_n = '0, kd_n = '0;
    logic [NCH*SHW-1:0]   kp_sh = '0, ki_sh = '0, kd_sh = '0;
    logic signed [W-1:0]  int_lim = 13'sd4095;
    logic signed [W-1:0]  pwm_max = 13'sd4095;
    logic                 clr_valid = 1'b0;
    logic [CHW-1:0]       clr_chan = '0;

    int checks = 0;
    int fails  = 0;
    int r_lat, r_pwm, r_err, r_int, r_dir, r_chan;

    pid_mc_if #(.NCH(NCH), .W(W)) bus ();

    pid_mc #(.NCH(NCH), .W(W), .SHW(SHW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mode     (mode),
        .kp_n     (kp_n),
        .ki_n     (ki_n),
        .kd_n     (kd_n),
        .kp_sh    (kp_sh),
        .ki_sh    (ki_sh),
        .kd_sh    (kd_sh),
        .int_lim  (int_lim),
        .pwm_max  (pwm_max),
        .clr_valid(clr_valid),
        .clr_chan (clr_chan)
    );

    always #5 clk = ~clk;

    task automatic set_gain(input int ch, input int kp, input int psh, input int ki,
                            input int ish, input int kd, input int dsh);
        kp_n[ch*W +: W] = W'(kp);   kp_sh[ch*SHW +: SHW] = SHW'(psh);
        ki_n[ch*W +: W] = W'(ki);   ki_sh[ch*SHW +: SHW] = SHW'(ish);
        kd_n[ch*W +: W] = W'(kd);   kd_sh[ch*SHW +: SHW] = SHW'(dsh);
    endtask

    // clr_at = k pulses clr_valid across the k-th edge after accept (0 = accept edge, -1 = none).
    task automatic run_sample(input int ch, input int pd, input int p, input int vd,
                              input int v, input int clr_at, input int clr_ch);
        for (int t = 0; t < 10 && !bus.in_ready; t++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_wait: in_ready=%0b required 1", bus.in_ready);
        end
        bus.in_chan = CHW'(ch);
        bus.pos_d = W'(pd); bus.pos = W'(p); bus.vel_d = W'(vd); bus.vel = W'(v);
        bus.in_valid = 1'b1;
        if (clr_at == 0) begin clr_valid = 1'b1; clr_chan = CHW'(clr_ch); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clr_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready: in_ready=%0b required 0", bus.in_ready);
        end
        r_lat = -1;
        for (int k = 1; k <= 10 && r_lat < 0; k++) begin
            if (k == clr_at) begin clr_valid = 1'b1; clr_chan = CHW'(clr_ch); end
            @(posedge clk); #1;
            clr_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                r_lat = k; r_pwm = int'(bus.pwm); r_err = int'(bus.err);
                r_int = int'(bus.int_err); r_dir = int'(bus.dir); r_chan = int'(bus.out_chan);
            end
        end
        $display("txn ch=%0d lat=%0d pwm=%0d dir=%0d err=%0d int_err=%0d out_chan=%0d",
                 ch, r_lat, r_pwm, r_dir, r_err, r_int, r_chan);
        checks++;
        if (r_lat != 5) begin
            fails++;
            $display("FAIL latency ch%0d: edges=%0d required 5", ch, r_lat);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: %0b required 0", bus.out_valid); end
        checks++; if (bus.pwm !== '0)         begin fails++; $display("FAIL rst_pwm: %0d required 0", bus.pwm); end
        checks++; if (bus.dir !== 1'b1)       begin fails++; $display("FAIL rst_dir: %0b required 1", bus.dir); end
        checks++; if (bus.err !== '0)         begin fails++; $display("FAIL rst_err: %0d required 0", bus.err); end
        checks++; if (bus.int_err !== '0)     begin fails++; $display("FAIL rst_int_err: %0d required 0", bus.int_err); end
        checks++; if (bus.out_chan !== '0)    begin fails++; $display("FAIL rst_out_chan: %0d required 0", bus.out_chan); end
        checks++; if (bus.in_ready !== 1'b1)  begin fails++; $display("FAIL rst_in_ready: %0b required 1", bus.in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_p();
        set_gain(0, 3, 1, 0, 0, 0, 0);
        run_sample(0, 100, 40, 0, 0, -1, 0);
        checks++; if (r_pwm != 90)  begin fails++; $display("FAIL basic_pwm: %0d required 90", r_pwm); end
        checks++; if (r_dir != 1)   begin fails++; $display("FAIL basic_dir: %0d required 1", r_dir); end
        checks++; if (r_err != 60)  begin fails++; $display("FAIL basic_err: %0d required 60", r_err); end
        checks++; if (r_int != 60)  begin fails++; $display("FAIL basic_int: %0d required 60", r_int); end
        checks++; if (r_chan != 0)  begin fails++; $display("FAIL basic_chan: %0d required 0", r_chan); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL strobe_width: out_valid=%0b required 0", bus.out_valid); end
        checks++; if (int'(bus.pwm) != 90)    begin fails++; $display("FAIL pwm_hold: %0d required 90", bus.pwm); end
    endtask

    task automatic test_anti_windup();
        int exp_i [3] = '{60, 100, 100};
        set_gain(1, 0, 0, 1, 0, 0, 0);
        int_lim = 13'sd100;
        for (int n = 0; n < 3; n++) begin
            run_sample(1, 100, 40, 0, 0, -1, 0);
            checks++; if (r_int != exp_i[n]) begin fails++; $display("FAIL windup_int[%0d]: %0d required %0d", n, r_int, exp_i[n]); end
            checks++; if (r_pwm != exp_i[n]) begin fails++; $display("FAIL windup_pwm[%0d]: %0d required %0d", n, r_pwm, exp_i[n]); end
        end
        int_lim = 13'sd4095;
    endtask

    task automatic test_derivative_sign();
        mode[2] = 1'b1;
        set_gain(2, 0, 0, 0, 0, 2, 0);
        run_sample(2, 0, 0, 30, 20, -1, 0);
        checks++; if (r_pwm != 20)  begin fails++; $display("FAIL deriv_pwm0: %0d required 20", r_pwm); end
        checks++; if (r_dir != 1)   begin fails++; $display("FAIL deriv_dir0: %0d required 1", r_dir); end
        run_sample(2, 0, 0, 0, 20, -1, 0);
        checks++; if (r_pwm != -60) begin fails++; $display("FAIL deriv_pwm1: %0d required -60", r_pwm); end
        checks++; if (r_dir != 0)   begin fails++; $display("FAIL deriv_dir1: %0d required 0", r_dir); end
        set_gain(3, 1, 2, 0, 0, 0, 0);
        run_sample(3, 0, 5, 0, 0, -1, 0);
        checks++; if (r_pwm != -2)  begin fails++; $display("FAIL floor_pwm: %0d required -2", r_pwm); end
        checks++; if (r_err != -5)  begin fails++; $display("FAIL floor_err: %0d required -5", r_err); end
        checks++; if (r_chan != 3)  begin fails++; $display("FAIL floor_chan: %0d required 3", r_chan); end
    endtask

    task automatic test_saturation();
        set_gain(0, 4095, 0, 0, 0, 0, 0);
        pwm_max = 13'sd2000;
        run_sample(0, 4000, -4000, 0, 0, -1, 0);
        checks++; if (r_err != 4095)  begin fails++; $display("FAIL sat_err_pos: %0d required 4095", r_err); end
        checks++; if (r_pwm != 2000)  begin fails++; $display("FAIL sat_pwm_pos: %0d required 2000", r_pwm); end
        pwm_max = 13'sd4095;
        run_sample(0, -4000, 4000, 0, 0, -1, 0);
        checks++; if (r_err != -4096) begin fails++; $display("FAIL sat_err_neg: %0d required -4096", r_err); end
        checks++; if (r_pwm != -4095) begin fails++; $display("FAIL sat_pwm_neg: %0d required -4095", r_pwm); end
        checks++; if (r_dir != 0)     begin fails++; $display("FAIL sat_dir_neg: %0d required 0", r_dir); end
    endtask

    task automatic test_independence_clear();
        set_gain(0, 0, 0, 1, 0, 0, 0);
        set_gain(1, 0, 0, 1, 0, 0, 0);
        clr_valid = 1'b1; clr_chan = 2'd0;
        @(posedge clk); #1;
        clr_chan = 2'd1;
        @(posedge clk); #1;
        clr_valid = 1'b0;
        run_sample(0, 10, 0, 0, 0, -1, 0);
        checks++; if (r_int != 10) begin fails++; $display("FAIL ind_ch0_a: %0d required 10", r_int); end
        run_sample(1, 20, 0, 0, 0, -1, 0);
        checks++; if (r_int != 20) begin fails++; $display("FAIL ind_ch1_a: %0d required 20", r_int); end
        run_sample(0, 10, 0, 0, 0, -1, 0);
        checks++; if (r_int != 20) begin fails++; $display("FAIL ind_ch0_b: %0d required 20", r_int); end
        run_sample(1, 20, 0, 0, 0, 3, 1);
        checks++; if (r_int != 40) begin fails++; $display("FAIL clr_mul_out: %0d required 40", r_int); end
        checks++; if (r_pwm != 40) begin fails++; $display("FAIL clr_mul_pwm: %0d required 40", r_pwm); end
        run_sample(1, 20, 0, 0, 0, -1, 0);
        checks++; if (r_int != 20) begin fails++; $display("FAIL clr_mul_next: %0d required 20", r_int); end
        run_sample(0, 10, 0, 0, 0, -1, 0);
        checks++; if (r_int != 30) begin fails++; $display("FAIL ind_ch0_c: %0d required 30", r_int); end
        run_sample(1, 20, 0, 0, 0, 5, 1);
        checks++; if (r_int != 40) begin fails++; $display("FAIL clr_sum_out: %0d required 40", r_int); end
        run_sample(1, 20, 0, 0, 0, -1, 0);
        checks++; if (r_int != 20) begin fails++; $display("FAIL clr_sum_next: %0d required 20", r_int); end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        set_gain(0, 0, 0, 1, 0, 1, 0);
        bus.in_chan = 2'd0; bus.pos_d = 13'sd7; bus.pos = '0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0)             begin fails++; $display("FAIL midrst_no_out: strobes=%0d required 0", seen); end
        checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: %0b required 1", bus.in_ready); end
        checks++; if (bus.pwm !== '0)        begin fails++; $display("FAIL midrst_pwm: %0d required 0", bus.pwm); end
        run_sample(0, 7, 0, 0, 0, -1, 0);
        checks++; if (r_int != 7)  begin fails++; $display("FAIL midrst_int: %0d required 7", r_int); end
        checks++; if (r_pwm != 14) begin fails++; $display("FAIL midrst_pwm_next: %0d required 14", r_pwm); end
        checks++; if (r_err != 7)  begin fails++; $display("FAIL midrst_err: %0d required 7", r_err); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_chan = '0;
        bus.pos_d = '0; bus.pos = '0; bus.vel_d = '0; bus.vel = '0;
        test_reset();
        test_basic_p();
        test_anti_windup();
        test_derivative_sign();
        test_saturation();
        test_independence_clear();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
